// File: rtl/mixcolumn_enc_serial.sv
// mixcolumn_enc_serial
// Forward AES MixColumns engine for the encrypt datapath. One 128-bit state is
// accepted through a valid/ready handshake, COLS_PER_CYCLE columns are mixed per
// clock, and the finished state is presented on a valid/ready output port.
// The final AES round skips MixColumns. It still takes the same FSM path and the
// same number of cycles, so the timing never depends on the data or on the mode.

module mixcolumn_enc_serial #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] b,
    input  logic         final_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] mixcolumn,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mixcolumn_enc_serial: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Counter value of the pass that writes the last group of columns, and the
    // stride between passes. With four columns per clock the stride wraps to 0,
    // which is harmless because the first pass is also the last one.
    localparam logic [1:0] LAST_COUNT = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] COUNT_STEP = 2'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       counter;
    logic             final_reg;

    // Column 0 sits at the MSB end, matching the byte/column packing of b.
    logic [0:3][31:0] src_cols;
    logic [0:3][31:0] work_cols;
    logic [0:3][31:0] work_next;

    logic [1:0]       col_idx;
    logic [31:0]      col_in;
    logic [31:0]      col_out;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply one column by the forward MixColumns matrix. Byte 0 is in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] a);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] o0;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [7:0] o3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        o0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        o1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        o2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        o3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {o0, o1, o2, o3};
    endfunction

    // Mix the group of columns selected by the counter. The mixed value is always
    // computed, and final_reg only picks between it and the untouched column.
    always_comb begin
        work_next = work_cols;
        col_idx   = counter;
        col_in    = '0;
        col_out   = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx            = counter + 2'(k);
            col_in             = src_cols[col_idx];
            col_out            = mix_column(col_in);
            work_next[col_idx] = final_reg ? col_in : col_out;
        end
    end

    // Handshake FSM. All outputs are registered. mixcolumn is loaded only when a
    // whole state is finished, so it keeps the previous result until a new one
    // replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            mixcolumn <= '0;
            counter   <= '0;
            final_reg <= 1'b0;
            src_cols  <= '0;
            work_cols <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        src_cols  <= b;
                        final_reg <= final_round;
                        counter   <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    work_cols <= work_next;
                    if (counter == LAST_COUNT) begin
                        mixcolumn <= work_next;
                        out_valid <= 1'b1;
                        counter   <= '0;
                        state     <= DONE;
                    end else begin
                        counter <= counter + COUNT_STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    counter   <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixcolumn_enc_serial.sv
// tb_mixcolumn_enc_serial
// Bench with three engines, one each for COLS_PER_CYCLE = 1, 2 and 4.
// A cycle-level behavioural model predicts the handshake and result of every
// engine. Directed AES vectors check literal results and latencies.

module tb_mixcolumn_enc_serial;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] b_in      [3];
    logic         final_in  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] mixcolumn [3];
    logic         busy      [3];

    int n_compared;
    int n_mismatched;
    bit checking;

    typedef enum int {M_IDLE, M_BUSY, M_DONE} mphase_t;

    mphase_t      m_phase [3];
    int           m_left  [3];
    logic [127:0] m_src   [3];
    logic         m_fin   [3];
    logic [127:0] m_out   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mixcolumn_enc_serial #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .b           (b_in[g]),
            .final_round (final_in[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .mixcolumn   (mixcolumn[g]),
            .busy        (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Apply a circulant matrix whose first row is coefs to every column of s.
    function automatic logic [127:0] mix_with(input logic [127:0] s, input logic [31:0] coefs);
        logic [127:0] res;
        logic [7:0]   acc;
        logic [7:0]   a;
        logic [7:0]   cf;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) begin
                    a   = 8'(s >> (120 - 32 * c - 8 * j));
                    cf  = 8'(coefs >> (24 - 8 * ((j - r + 4) % 4)));
                    acc ^= gf_mul(a, cf);
                end
                res = {res[119:0], acc};
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        return mix_with(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        return mix_with(s, 32'h0e0b0d09);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
        end
    endtask

    // Behavioural model: idle -> busy for 4/COLS clocks -> done until retired.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_phase[i] <= M_IDLE;
                m_out[i]   <= '0;
                m_left[i]  <= 0;
            end else begin
                case (m_phase[i])
                    M_IDLE: if (in_valid[i]) begin
                        m_src[i]   <= b_in[i];
                        m_fin[i]   <= final_in[i];
                        m_left[i]  <= 4 >> i;
                        m_phase[i] <= M_BUSY;
                    end
                    M_BUSY: begin
                        m_left[i] <= m_left[i] - 1;
                        if (m_left[i] == 1) begin
                            m_phase[i] <= M_DONE;
                            m_out[i]   <= m_fin[i] ? m_src[i] : fwd_mix(m_src[i]);
                        end
                    end
                    default: if (out_ready[i]) m_phase[i] <= M_IDLE;
                endcase
            end
        end
    end

    // Compare every engine against the model on each falling edge.
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("in_ready[%0d]", i), 128'(in_ready[i]), 128'(m_phase[i] == M_IDLE));
                checkOutput($sformatf("out_valid[%0d]", i), 128'(out_valid[i]), 128'(m_phase[i] == M_DONE));
                checkOutput($sformatf("busy[%0d]", i), 128'(busy[i]), 128'(m_phase[i] != M_IDLE));
                if (m_phase[i] != M_BUSY)
                    checkOutput($sformatf("mixcolumn[%0d]", i), mixcolumn[i], m_out[i]);
                if (m_phase[i] == M_DONE && !m_fin[i])
                    checkOutput($sformatf("roundtrip[%0d]", i), inv_mix(mixcolumn[i]), m_src[i]);
            end
        end
    end

    // Present one state once the engine is idle, and return just after the accept edge.
    task automatic startOnly(input int idx, input logic [127:0] data, input logic fin);
        int guard;
        guard = 0;
        while (m_phase[idx] != M_IDLE && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("idle_wait", 128'(guard < 50), 128'(1));
        in_valid[idx] = 1'b1;
        b_in[idx]     = data;
        final_in[idx] = fin;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        b_in[idx]     = {$urandom, $urandom, $urandom, $urandom};
        final_in[idx] = 1'($urandom);
    endtask

    // Present a state and count the clocks from the accept edge to out_valid.
    task automatic applyStimulus(input int idx, input logic [127:0] data, input logic fin, output int lat);
        startOnly(idx, data, fin);
        lat = 0;
        while (!out_valid[idx] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retireResult(input int idx, input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready[idx] = 1'b0;
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] R1_IN    = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] R1_OUT   = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] FIN_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        int lat;
        logic [127:0] rnd;
        n_compared   = 0;
        n_mismatched = 0;
        checking     = 1'b0;
        rst          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            b_in[i]      = '0;
            final_in[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        checking = 1'b1;
        checkOutput("reset_mixcolumn", mixcolumn[0], 128'h0);
        checkOutput("reset_in_ready", 128'(in_ready[0]), 128'(1));

        $display("[TB] FIPS-197 vector, one column per clock");
        applyStimulus(0, FIPS_IN, 1'b0, lat);
        checkOutput("fips_latency", 128'(lat), 128'(4));
        checkOutput("fips_result", mixcolumn[0], FIPS_OUT);
        retireResult(0, 0);

        $display("[TB] round-1 state on all three widths");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i, R1_IN, 1'b0, lat);
            checkOutput($sformatf("r1_latency[%0d]", i), 128'(lat), 128'(4 >> i));
            checkOutput($sformatf("r1_result[%0d]", i), mixcolumn[i], R1_OUT);
            retireResult(i, 1);
            checkOutput($sformatf("r1_kept[%0d]", i), mixcolumn[i], R1_OUT);
        end

        $display("[TB] final round pass-through");
        for (int i = 0; i < 3; i += 2) begin
            applyStimulus(i, FIN_IN, 1'b1, lat);
            checkOutput($sformatf("final_latency[%0d]", i), 128'(lat), 128'(4 >> i));
            checkOutput($sformatf("final_result[%0d]", i), mixcolumn[i], FIN_IN);
            retireResult(i, 0);
        end

        $display("[TB] backpressure hold and retire");
        applyStimulus(0, FIPS_IN, 1'b0, lat);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checkOutput("hold_out_valid", 128'(out_valid[0]), 128'(1));
            checkOutput("hold_in_ready", 128'(in_ready[0]), 128'(0));
            checkOutput("hold_result", mixcolumn[0], FIPS_OUT);
        end
        in_valid[0]  = 1'b1;
        b_in[0]      = R1_IN;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        checkOutput("retire_in_ready", 128'(in_ready[0]), 128'(1));
        checkOutput("retire_no_accept", 128'(busy[0]), 128'(0));

        $display("[TB] reset in the second busy cycle");
        startOnly(0, R1_IN, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_out_valid", 128'(out_valid[0]), 128'(0));
        checkOutput("rst_mixcolumn", mixcolumn[0], 128'h0);
        checkOutput("rst_in_ready", 128'(in_ready[0]), 128'(1));
        applyStimulus(0, R1_IN, 1'b0, lat);
        checkOutput("post_rst_latency", 128'(lat), 128'(4));
        checkOutput("post_rst_result", mixcolumn[0], R1_OUT);
        retireResult(0, 0);

        $display("[TB] random states with inverse round trip");
        for (int n = 0; n < 1000; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(n % 3, rnd, 1'(n % 10 == 9), lat);
            checkOutput("rand_latency", 128'(lat), 128'(4 >> (n % 3)));
            retireResult(n % 3, int'($urandom_range(0, 2)));
        end

        @(posedge clk); #1;
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
